// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose : Shared definitions for the bit-serial adder.
//           - state_e       : controller state encoding
//           - DEFAULT_WIDTH : default operand/result width
//           - ovf_flag()    : signed-overflow helper (carry into MSB vs carry out)
//
// Ports   : none (package)
// ----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement overflow occurs when the carry entering the sign bit
    // differs from the carry leaving it.
    function automatic logic ovf_flag(input logic carry_into_msb, input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//
// Purpose : One-bit full-adder cell, purely combinational.
//
// Ports   : sum  - output, a ^ b ^ cin
//           cout - output, majority(a, b, cin)
//           a    - input, addend bit A
//           b    - input, addend bit B
//           cin  - input, carry-in bit
// ----------------------------------------------------------------------------
module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//
// Purpose : Bit-serial adder computing a + b + cin one bit per clock, LSB
//           first, through a single full_adder cell. Operands are captured on
//           the accept edge, so input changes during the addition are
//           ignored. The result is held in DONE until the downstream
//           handshake completes.
//
// Config  : SERIAL_ADDER_OVF_EN - when defined, ovf reports signed overflow
//           captured on the final ADD cycle; when undefined, ovf is tied to 0.
//
// Ports   : clk       - input,  sole clock, rising edge
//           rst       - input,  synchronous active-high reset
//           in_valid  - input,  operand set a/b/cin presented
//           in_ready  - output, high only in IDLE
//           a, b      - input  [WIDTH-1:0], addends
//           cin       - input,  carry-in
//           out_valid - output, high only in DONE
//           out_ready - input,  downstream accepts result
//           sum       - output [WIDTH-1:0], a+b+cin mod 2^WIDTH
//           cout      - output, carry out of the MSB
//           ovf       - output, signed overflow (0 when feature disabled)
// ----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               carry_q,     carry_d;
    logic [CW-1:0]      cnt_q,       cnt_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               fa_sum;
    logic               fa_cout;
    logic               last_add;

    // Single full-adder cell shared across all bit positions.
    full_adder u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q)
    );

    assign last_add = (state_q == ADD) && (cnt_q == LAST_CNT);

    // Next-state, datapath and handshake-flag computation.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                // in_ready is implied by being in IDLE.
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                // Operands shift toward bit 0 so the full adder always sees
                // the current bit pair; the sum bit enters from the MSB side
                // and lands in its final position after WIDTH shifts.
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                // Only the output handshake completes here; a new operand
                // set is taken the following cycle from IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and handshake-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    // After the final ADD cycle the carry register holds the MSB carry-out.
    assign cout      = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow capture: carry_q is the carry into the MSB on the last cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (last_add) begin
            ovf_d = ovf_flag(carry_q, fa_cout);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_last_add;
    assign unused_last_add = last_add;
    assign ovf             = 1'b0;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//
// Purpose : Self-checking bench for serial_adder (WIDTH=8). Expected results
//           are computed by a reference model when operands are driven, queued
//           in a scoreboard, and popped when the DUT raises out_valid.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int   vectors_applied = 0;
    int   miscompares     = 0;
    exp_t sb_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer addition plus carry into bit 7.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] full;
        logic [7:0] low;
        exp_t       e;
        full   = {1'b0, x} + {1'b0, y} + {8'd0, c};
        low    = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, c};
        e.sum  = full[7:0];
        e.cout = full[8];
`ifdef SERIAL_ADDER_OVF_EN
        e.ovf  = low[7] ^ full[8];
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    // Drive one operation from IDLE (called at a negedge), optionally toggle
    // inputs during ADD, optionally stall the output for 'hold' cycles while
    // offering new operands, then complete the handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                          input int hold, input bit toggle);
        int   lat;
        exp_t e;
        check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a         = ta;
        b         = tb2;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb_q.push_back(model(ta, tb2, tc));
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (toggle) begin
                a        = 8'($urandom);
                b        = 8'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check_val("latency", 32'(lat), 32'd9);
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        check_val("sum",  {24'd0, sum},  {24'd0, e.sum});
        check_val("cout", {31'd0, cout}, {31'd0, e.cout});
        check_val("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
        for (int i = 0; i < hold; i++) begin
            a        = 8'h5A + 8'(i);
            b        = 8'hC3 ^ 8'(i);
            cin      = 1'(i);
            in_valid = 1'b1;
            @(negedge clk);
            check_val("hold_sum",      {24'd0, sum},       {24'd0, e.sum});
            check_val("hold_in_ready", {31'd0, in_ready},  32'd0);
            check_val("hold_out_vld",  {31'd0, out_valid}, 32'd1);
        end
        // Simultaneous in_valid on the handshake edge must not be accepted.
        in_valid  = (hold > 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_val("post_hs_out_vld",  {31'd0, out_valid}, 32'd0);
        check_val("post_hs_in_ready", {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        bit saw_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_sum",       {24'd0, sum},       32'd0);
        check_val("rst_cout",      {31'd0, cout},      32'd0);
        check_val("rst_ovf",       {31'd0, ovf},       32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h0F, 8'h01, 1'b0, 5, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);

        // Reset in the 4th ADD cycle abandons the operation.
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_sum",       {24'd0, sum},       32'd0);
        check_val("mid_rst_cout",      {31'd0, cout},      32'd0);
        check_val("mid_rst_ovf",       {31'd0, ovf},       32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check_val("mid_rst_no_result", {31'd0, saw_valid}, 32'd0);
        run_op(8'h03, 8'h04, 1'b0, 0, 1'b0);

        // Operand changes during ADD must not disturb the captured operands.
        run_op(8'h12, 8'h34, 1'b0, 0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), i % 3, 1'(i % 2));
        end

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/cin presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  addend A, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  addend B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  sum/cout/ovf valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port sum  output  WIDTH  registered result a+b+cin mod 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of MSB.
REQ-013 SHALL have port ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, ADD, DONE; IDLE->ADD on in_valid&&in_ready; ADD->DONE after WIDTH ADD cycles; DONE->IDLE on out_valid&&out_ready.
REQ-015 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE; no bypass.
REQ-016 On accept edge SHALL load a, b into shift registers, carry register <= cin, bit counter <= 0.
REQ-017 Each ADD cycle SHALL add one bit pair, LSB first, through one full-adder cell with the carry register, store its carry, and shift the sum bit into the result register from the MSB side.
REQ-018 Latency SHALL be fixed: out_valid rises WIDTH+1 cycles after the accept edge; throughput is one operation per WIDTH+2 cycles minimum.
REQ-019 cout SHALL be the carry register after the final ADD cycle.
REQ-020 sum, cout, ovf SHALL remain stable throughout DONE until handshake completes (out_ready held low -> indefinite hold).
REQ-021 in_valid asserted while not in IDLE SHALL be ignored; a/b/cin changes during ADD SHALL not affect the result.
REQ-022 Bit counter SHALL be $clog2(WIDTH+1) bits and SHALL not wrap within an operation.
REQ-023 In DONE, simultaneous out_ready and in_valid SHALL complete only the output handshake; new input is accepted the following cycle in IDLE.

Reset
REQ-024 rst high at a rising edge SHALL force IDLE, sum=0, cout=0, ovf=0, out_valid=0, carry=0, counter=0; in_ready=1 the cycle after.
REQ-025 rst asserted mid-ADD or in DONE SHALL abandon the operation with no result produced; rst SHALL take priority over all handshakes.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN defined: ovf SHALL equal carry-into-MSB XOR cout, captured on the final ADD cycle.
REQ-027 Macro undefined: ovf port SHALL remain present and SHALL be constant 0; no extra flops inferred.

Structure
REQ-028 Shared package serial_adder_pkg SHALL hold state encoding (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and DEFAULT_WIDTH=8.
REQ-029 The per-bit addition SHALL use one instance of the existing full_adder cell (sum, cout, a, b, cin); all sequencing remains in serial_adder.

Verification (WIDTH=8)
REQ-030 a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, out_valid exactly 9 cycles after accept edge.
REQ-031 a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-032 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; ovf=1 with SERIAL_ADDER_OVF_EN, ovf=0 without.
REQ-033 Result 0x10 held with out_ready=0 for 5 cycles, in_valid=1 with new operands -> sum stable, in_ready=0, next accept only after out_ready handshake plus one cycle.
REQ-034 rst pulsed on 4th ADD cycle of a=0xAA, b=0x55 -> next cycle IDLE, all outputs 0, no out_valid; following a=0x03, b=0x04 -> sum=0x07.
REQ-035 a/b toggled randomly during ADD after accepting a=0x12, b=0x34 -> sum=0x46, cout=0.
